// File: rtl/tff_pkg.sv
// tff_pkg: direction encodings and a ceil-log2 helper for parameter checks
package tff_pkg;
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single toggle flip-flop, Q flips on each rising edge with T high
module tff_cell (
   input  logic T,
   input  logic clock,
   input  logic reset_n,
   output logic Q,
   output logic notQ
);
   logic q_d, q_q;
   always_comb q_d = q_q ^ T;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) q_q <= 1'b0;
      else q_q <= q_d;
   assign Q    = q_q;
   assign notQ = ~q_q;
endmodule

// File: rtl/tff_counter.sv
// tff_counter: modulo up/down counter built from a column of toggle cells,
// with parallel load, combinational terminal count and registered wrap/load_err pulses
module tff_counter
   import tff_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] notCount,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   localparam bit FULL = (MODULUS == 2 ** WIDTH);

   if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
      $error("tff_counter: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
   end

   logic [WIDTH-1:0] t_d, t_up, t_dn, target;
   logic load_ok, at_end, wrap_d, wrap_q, load_err_d, load_err_q;

   genvar i;
   for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
         assign t_up[i] = 1'b1;
         assign t_dn[i] = 1'b1;
      end else begin : g_upper
         assign t_up[i] = &count[i-1:0];
         assign t_dn[i] = ~|count[i-1:0];
      end
      tff_cell u_cell (
         .T      (t_d[i]),
         .clock  (clock),
         .reset_n(reset_n),
         .Q      (count[i]),
         .notQ   (notCount[i])
      );
   end

   // Load and short-modulus wraps jump straight to a target by toggling the differing bits
   always_comb begin
      load_ok    = {1'b0, load_value} < (WIDTH+1)'(MODULUS);
      at_end     = (up == DIR_UP) ? (count == MAX) : (count == '0);
      target     = load ? (load_ok ? load_value : MAX) : (up == DIR_DOWN) ? MAX : '0;
      tc         = enable & ~load & at_end;
      t_d        = (load || (tc && !FULL)) ? count ^ target
                 : !enable ? '0
                 : (up == DIR_UP) ? t_up : t_dn;
      wrap_d     = tc;
      load_err_d = load & ~load_ok;
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end

   assign wrap     = wrap_q;
   assign load_err = load_err_q;
endmodule

// File: tb/tb_tff_counter.sv
// tb_tff_counter: directed and randomized checks of tff_counter against an arithmetic model
module tb_tff_counter;
   localparam int MOD = 10;
   logic clock, reset_n, enable, up, load;
   logic [3:0] load_value, count, not_count;
   logic tc, wrap, load_err;
   logic b_en, b_up, b_ld;
   logic [2:0] b_lv, b_count, b_not;
   logic b_tc, b_wrap, b_err;
   int checks, errors, m, mw, me;

   tff_counter #(.WIDTH(4), .MODULUS(MOD)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .up(up), .load(load),
      .load_value(load_value), .count(count), .notCount(not_count), .tc(tc),
      .wrap(wrap), .load_err(load_err));

   tff_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
      .clock(clock), .reset_n(reset_n), .enable(b_en), .up(b_up), .load(b_ld),
      .load_value(b_lv), .count(b_count), .notCount(b_not), .tc(b_tc),
      .wrap(b_wrap), .load_err(b_err));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(m));
      chk({tag, ".notCount"}, 32'(not_count), 32'(15 - m));
      chk({tag, ".wrap"}, 32'(wrap), 32'(mw));
      chk({tag, ".load_err"}, 32'(load_err), 32'(me));
   endtask

   // Apply controls, check tc before the edge, advance the model, check outputs after
   task automatic step(input string tag, input logic e, input logic u, input logic l,
                       input logic [3:0] lv);
      enable = e; up = u; load = l; load_value = lv;
      #1;
      chk({tag, ".tc"}, 32'(tc), 32'(!l && e && (u ? m == MOD - 1 : m == 0)));
      @(posedge clock);
      if (l) begin
         mw = 0;
         me = int'(lv) >= MOD;
         m  = me ? MOD - 1 : int'(lv);
      end else if (e) begin
         mw = u ? (m == MOD - 1) : (m == 0);
         m  = u ? (m + 1) % MOD : (m + MOD - 1) % MOD;
         me = 0;
      end else begin
         mw = 0;
         me = 0;
      end
      #1;
      chk_outputs(tag);
   endtask

   initial begin
      int bm, bw, wraps;
      checks = 0; errors = 0; m = 0; mw = 0; me = 0;
      reset_n = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = '0;
      b_en = 1'b0; b_up = 1'b1; b_ld = 1'b0; b_lv = '0;
      #3;
      chk_outputs("reset");
      #5 reset_n = 1'b1;

      step("t1_load7", 1'b0, 1'b1, 1'b1, 4'd7);
      #2 reset_n = 1'b0;
      #1;
      m = 0; mw = 0; me = 0;
      chk_outputs("t1_async");
      enable = 1'b1;
      @(posedge clock);
      #1;
      chk_outputs("t1_held");
      #2 reset_n = 1'b1;

      for (int k = 0; k < 12; k++) step("t2_up", 1'b1, 1'b1, 1'b0, 4'd0);
      step("t3_load1", 1'b0, 1'b0, 1'b1, 4'd1);
      for (int k = 0; k < 3; k++) step("t3_down", 1'b1, 1'b0, 1'b0, 4'd0);
      step("t4_load2", 1'b0, 1'b1, 1'b1, 4'd2);
      step("t4_load5", 1'b1, 1'b1, 1'b1, 4'd5);
      step("t4_load12", 1'b1, 1'b1, 1'b1, 4'd12);
      step("t4_after", 1'b0, 1'b1, 1'b0, 4'd0);
      step("t4_load15", 1'b0, 1'b0, 1'b1, 4'd15);
      step("t5_load3", 1'b0, 1'b1, 1'b1, 4'd3);
      step("t5_en1", 1'b1, 1'b1, 1'b0, 4'd0);
      step("t5_en0a", 1'b0, 1'b1, 1'b0, 4'd0);
      step("t5_en0b", 1'b0, 1'b1, 1'b0, 4'd0);
      step("t5_en1b", 1'b1, 1'b1, 1'b0, 4'd0);

      for (int k = 0; k < 300; k++)
         step("rand", ($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 8) == 0,
              4'($urandom % 16));

      enable = 1'b0; load = 1'b0;
      bm = 0; wraps = 0;
      b_en = 1'b1; b_up = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock);
         bw = (bm == 7);
         bm = (bm + 1) % 8;
         wraps += bw;
         #1;
         chk("t6.count", 32'(b_count), 32'(bm));
         chk("t6.notCount", 32'(b_not), 32'(7 - bm));
         chk("t6.wrap", 32'(b_wrap), 32'(bw));
         chk("t6.load_err", 32'(b_err), 32'd0);
      end
      b_en = 1'b0;
      @(posedge clock);
      #1;
      wraps += b_wrap;
      chk("t6.wraps", 32'(wraps), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
